dm_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the single-port data memory (dm).
- Port 0 is the processor core load/store path; port 1 is the bench/loader path.
- Serializes accesses with round-robin fairness and a per-port lock for multi-access sequences such as read-modify-write.
- Uses a registered req/ack handshake and drives the dm port signals MemAdr, DatIn, ReadEn and WriteEn, and takes in DatOut.

---
 rtl/dm_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_dm_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port arbiter/sequencer in front of the single-port data memory.
// Port 0 is the core load/store path, port 1 the bench/loader path. Accesses are
// serialized with round-robin fairness; a port holding lock keeps ownership for
// multi-access sequences such as read-modify-write.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   pX_req/we/lock/adr/wdat        port X request, write/read, lock, address, write data
//   pX_ack, pX_rdat                port X one-cycle completion pulse, read data (registered)
//   MemAdr, DatIn, ReadEn, WriteEn dm port drive (decoded from state, zero outside ACC)
//   DatOut                         dm combinational read data
//   owner                          0 = none, 1 = port 0, 2 = port 1
module dm_arbiter #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic          p0_lock,
    input  logic [AW-1:0] p0_adr,
    input  logic [DW-1:0] p0_wdat,
    output logic          p0_ack,
    output logic [DW-1:0] p0_rdat,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic          p1_lock,
    input  logic [AW-1:0] p1_adr,
    input  logic [DW-1:0] p1_wdat,
    output logic          p1_ack,
    output logic [DW-1:0] p1_rdat,
    output logic [AW-1:0] MemAdr,
    output logic [DW-1:0] DatIn,
    input  logic [DW-1:0] DatOut,
    output logic          ReadEn,
    output logic          WriteEn,
    output logic [1:0]    owner
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC0,
        S_RSP0,
        S_LOCK0,
        S_ACC1,
        S_RSP1,
        S_LOCK1
    } state_e;

    state_e        state_q, state_d;
    logic          rr_q, rr_d;
    logic          p0_ack_q, p0_ack_d;
    logic          p1_ack_q, p1_ack_d;
    logic [DW-1:0] p0_rdat_q, p0_rdat_d;
    logic [DW-1:0] p1_rdat_q, p1_rdat_d;

    // State and registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rr_q      <= 1'b0;
            p0_ack_q  <= 1'b0;
            p1_ack_q  <= 1'b0;
            p0_rdat_q <= '0;
            p1_rdat_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            p0_ack_q  <= p0_ack_d;
            p1_ack_q  <= p1_ack_d;
            p0_rdat_q <= p0_rdat_d;
            p1_rdat_q <= p1_rdat_d;
        end
    end

    // Next-state, memory port decode and ownership
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        p0_ack_d  = 1'b0;
        p1_ack_d  = 1'b0;
        p0_rdat_d = p0_rdat_q;
        p1_rdat_d = p1_rdat_q;
        MemAdr    = '0;
        DatIn     = '0;
        ReadEn    = 1'b0;
        WriteEn   = 1'b0;
        owner     = 2'd0;

        case (state_q)
            S_IDLE: begin
                // rr_q names the port that wins a tie
                if (p0_req && (!p1_req || !rr_q)) begin
                    state_d = S_ACC0;
                end else if (p1_req) begin
                    state_d = S_ACC1;
                end
            end
            S_ACC0: begin
                owner   = 2'd1;
                MemAdr  = p0_adr;
                DatIn   = p0_wdat;
                WriteEn = p0_req & p0_we;
                ReadEn  = p0_req & ~p0_we;
                if (p0_req) begin
                    p0_ack_d = 1'b1;
                    if (!p0_we) begin
                        p0_rdat_d = DatOut;
                    end
                    state_d = S_RSP0;
                end else begin
                    // Request withdrawn before completion: abandon without ack
                    state_d = S_IDLE;
                    rr_d    = 1'b1;
                end
            end
            S_RSP0: begin
                owner = 2'd1;
                if (p0_lock) begin
                    state_d = S_LOCK0;
                end else begin
                    state_d = S_IDLE;
                    rr_d    = 1'b1;
                end
            end
            S_LOCK0: begin
                owner = 2'd1;
                if (p0_req) begin
                    state_d = S_ACC0;
                end else if (!p0_lock) begin
                    state_d = S_IDLE;
                    rr_d    = 1'b1;
                end
            end
            S_ACC1: begin
                owner   = 2'd2;
                MemAdr  = p1_adr;
                DatIn   = p1_wdat;
                WriteEn = p1_req & p1_we;
                ReadEn  = p1_req & ~p1_we;
                if (p1_req) begin
                    p1_ack_d = 1'b1;
                    if (!p1_we) begin
                        p1_rdat_d = DatOut;
                    end
                    state_d = S_RSP1;
                end else begin
                    state_d = S_IDLE;
                    rr_d    = 1'b0;
                end
            end
            S_RSP1: begin
                owner = 2'd2;
                if (p1_lock) begin
                    state_d = S_LOCK1;
                end else begin
                    state_d = S_IDLE;
                    rr_d    = 1'b0;
                end
            end
            S_LOCK1: begin
                owner = 2'd2;
                if (p1_req) begin
                    state_d = S_ACC1;
                end else if (!p1_lock) begin
                    state_d = S_IDLE;
                    rr_d    = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // No memory write may land in a reset cycle
        if (reset) begin
            WriteEn = 1'b0;
        end
    end

    assign p0_ack  = p0_ack_q;
    assign p1_ack  = p1_ack_q;
    assign p0_rdat = p0_rdat_q;
    assign p1_rdat = p1_rdat_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed, table-driven bench for dm_arbiter with a behavioural dm model.
module tb_dm_arbiter;

    logic       clk;
    logic       reset;
    logic       p0_req, p0_we, p0_lock;
    logic [7:0] p0_adr, p0_wdat;
    logic       p0_ack;
    logic [7:0] p0_rdat;
    logic       p1_req, p1_we, p1_lock;
    logic [7:0] p1_adr, p1_wdat;
    logic       p1_ack;
    logic [7:0] p1_rdat;
    logic [7:0] MemAdr, DatIn, DatOut;
    logic       ReadEn, WriteEn;
    logic [1:0] owner;

    logic       mem_init;
    logic [7:0] mem [0:255];

    int checks;
    int failures;

    dm_arbiter #(.AW(8), .DW(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .p0_req  (p0_req),
        .p0_we   (p0_we),
        .p0_lock (p0_lock),
        .p0_adr  (p0_adr),
        .p0_wdat (p0_wdat),
        .p0_ack  (p0_ack),
        .p0_rdat (p0_rdat),
        .p1_req  (p1_req),
        .p1_we   (p1_we),
        .p1_lock (p1_lock),
        .p1_adr  (p1_adr),
        .p1_wdat (p1_wdat),
        .p1_ack  (p1_ack),
        .p1_rdat (p1_rdat),
        .MemAdr  (MemAdr),
        .DatIn   (DatIn),
        .DatOut  (DatOut),
        .ReadEn  (ReadEn),
        .WriteEn (WriteEn),
        .owner   (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port dm: combinational read, write at posedge
    assign DatOut = mem[MemAdr];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h10] <= 8'hA5;
            mem[8'h05] <= 8'h07;
            mem[8'h30] <= 8'h11;
        end else if (WriteEn) begin
            mem[MemAdr] <= DatIn;
        end
    end

    // One cycle of stimulus and the outputs expected in that same cycle
    typedef struct packed {
        logic       r0, w0, l0;
        logic [7:0] a0, d0;
        logic       r1, w1, l1;
        logic [7:0] a1, d1;
        logic       ack0;
        logic [7:0] rd0;
        logic       ack1;
        logic [7:0] rd1;
        logic [7:0] madr, din;
        logic       re, we;
        logic [1:0] own;
    } vec_t;

    localparam int unsigned NVEC = 20;
    vec_t tbl [NVEC];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic r0, input logic w0, input logic l0,
                          input logic [7:0] a0, input logic [7:0] d0,
                          input logic r1, input logic w1, input logic l1,
                          input logic [7:0] a1, input logic [7:0] d1);
        p0_req = r0; p0_we = w0; p0_lock = l0; p0_adr = a0; p0_wdat = d0;
        p1_req = r1; p1_we = w1; p1_lock = l1; p1_adr = a1; p1_wdat = d1;
    endtask

    // Advance to just after the next active edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        mem_init = 1'b1;
        set_in(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);

        //            r0 w0 l0 a0     d0     r1 w1 l1 a1     d1      ack0 rd0   ack1 rd1    madr   din    re we own
        tbl[0]  = '{1'b1,1'b0,1'b0,8'h10,8'h00,1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00,1'b0,8'h00,8'h00,8'h00,1'b0,1'b0,2'd0};
        tbl[1]  = '{1'b1,1'b0,1'b0,8'h10,8'h00,1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,8'h00,1'b0,8'h00,8'h10,8'h00,1'b1,1'b0,2'd1};
        tbl[2]  = '{1'b1,1'b0,1'b0,8'h10,8'h00,1'b0,1'b0,1'b0,8'h00,8'h00, 1'b1,8'hA5,1'b0,8'h00,8'h00,8'h00,1'b0,1'b0,2'd1};
        tbl[3]  = '{1'b0,1'b0,1'b0,8'h00,8'h00,1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,8'hA5,1'b0,8'h00,8'h00,8'h00,1'b0,1'b0,2'd0};
        tbl[4]  = '{1'b0,1'b0,1'b0,8'h00,8'h00,1'b1,1'b1,1'b0,8'h20,8'h3C, 1'b0,8'hA5,1'b0,8'h00,8'h00,8'h00,1'b0,1'b0,2'd0};
        tbl[5]  = '{1'b0,1'b0,1'b0,8'h00,8'h00,1'b1,1'b1,1'b0,8'h20,8'h3C, 1'b0,8'hA5,1'b0,8'h00,8'h20,8'h3C,1'b0,1'b1,2'd2};
        tbl[6]  = '{1'b0,1'b0,1'b0,8'h00,8'h00,1'b1,1'b1,1'b0,8'h20,8'h3C, 1'b0,8'hA5,1'b1,8'h00,8'h00,8'h00,1'b0,1'b0,2'd2};
        tbl[7]  = '{1'b0,1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,1'b0,8'h20,8'h00, 1'b0,8'hA5,1'b0,8'h00,8'h00,8'h00,1'b0,1'b0,2'd0};
        tbl[8]  = '{1'b0,1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,1'b0,8'h20,8'h00, 1'b0,8'hA5,1'b0,8'h00,8'h20,8'h00,1'b1,1'b0,2'd2};
        tbl[9]  = '{1'b0,1'b0,1'b0,8'h00,8'h00,1'b1,1'b0,1'b0,8'h20,8'h00, 1'b0,8'hA5,1'b1,8'h3C,8'h00,8'h00,1'b0,1'b0,2'd2};
        tbl[10] = '{1'b1,1'b0,1'b0,8'h10,8'h00,1'b1,1'b0,1'b0,8'h20,8'h00, 1'b0,8'hA5,1'b0,8'h3C,8'h00,8'h00,1'b0,1'b0,2'd0};
        tbl[11] = '{1'b1,1'b0,1'b0,8'h10,8'h00,1'b1,1'b0,1'b0,8'h20,8'h00, 1'b0,8'hA5,1'b0,8'h3C,8'h10,8'h00,1'b1,1'b0,2'd1};
        tbl[12] = '{1'b1,1'b0,1'b0,8'h10,8'h00,1'b1,1'b0,1'b0,8'h20,8'h00, 1'b1,8'hA5,1'b0,8'h3C,8'h00,8'h00,1'b0,1'b0,2'd1};
        tbl[13] = '{1'b1,1'b0,1'b0,8'h05,8'h00,1'b1,1'b0,1'b0,8'h20,8'h00, 1'b0,8'hA5,1'b0,8'h3C,8'h00,8'h00,1'b0,1'b0,2'd0};
        tbl[14] = '{1'b1,1'b0,1'b0,8'h05,8'h00,1'b1,1'b0,1'b0,8'h20,8'h00, 1'b0,8'hA5,1'b0,8'h3C,8'h20,8'h00,1'b1,1'b0,2'd2};
        tbl[15] = '{1'b1,1'b0,1'b0,8'h05,8'h00,1'b1,1'b0,1'b0,8'h20,8'h00, 1'b0,8'hA5,1'b1,8'h3C,8'h00,8'h00,1'b0,1'b0,2'd2};
        tbl[16] = '{1'b1,1'b0,1'b0,8'h05,8'h00,1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,8'hA5,1'b0,8'h3C,8'h00,8'h00,1'b0,1'b0,2'd0};
        tbl[17] = '{1'b1,1'b0,1'b0,8'h05,8'h00,1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,8'hA5,1'b0,8'h3C,8'h05,8'h00,1'b1,1'b0,2'd1};
        tbl[18] = '{1'b1,1'b0,1'b0,8'h05,8'h00,1'b0,1'b0,1'b0,8'h00,8'h00, 1'b1,8'h07,1'b0,8'h3C,8'h00,8'h00,1'b0,1'b0,2'd1};
        tbl[19] = '{1'b0,1'b0,1'b0,8'h00,8'h00,1'b0,1'b0,1'b0,8'h00,8'h00, 1'b0,8'h07,1'b0,8'h3C,8'h00,8'h00,1'b0,1'b0,2'd0};

        // Reset state
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("reset p0_ack", 32'(p0_ack), 32'd0);
        chk("reset p1_ack", 32'(p1_ack), 32'd0);
        chk("reset p0_rdat", 32'(p0_rdat), 32'd0);
        chk("reset p1_rdat", 32'(p1_rdat), 32'd0);
        chk("reset owner", 32'(owner), 32'd0);
        chk("reset WriteEn", 32'(WriteEn), 32'd0);
        next_cycle();
        reset    = 1'b0;
        mem_init = 1'b0;

        // Single read, single write + readback, contention with round-robin
        for (int i = 0; i < int'(NVEC); i++) begin
            set_in(tbl[i].r0, tbl[i].w0, tbl[i].l0, tbl[i].a0, tbl[i].d0,
                   tbl[i].r1, tbl[i].w1, tbl[i].l1, tbl[i].a1, tbl[i].d1);
            @(negedge clk);
            chk($sformatf("row%0d p0_ack", i), 32'(p0_ack), 32'(tbl[i].ack0));
            chk($sformatf("row%0d p0_rdat", i), 32'(p0_rdat), 32'(tbl[i].rd0));
            chk($sformatf("row%0d p1_ack", i), 32'(p1_ack), 32'(tbl[i].ack1));
            chk($sformatf("row%0d p1_rdat", i), 32'(p1_rdat), 32'(tbl[i].rd1));
            chk($sformatf("row%0d MemAdr", i), 32'(MemAdr), 32'(tbl[i].madr));
            chk($sformatf("row%0d DatIn", i), 32'(DatIn), 32'(tbl[i].din));
            chk($sformatf("row%0d ReadEn", i), 32'(ReadEn), 32'(tbl[i].re));
            chk($sformatf("row%0d WriteEn", i), 32'(WriteEn), 32'(tbl[i].we));
            chk($sformatf("row%0d owner", i), 32'(owner), 32'(tbl[i].own));
            next_cycle();
        end
        chk("mem20 after write", 32'(mem[8'h20]), 32'h3C);

        // Locked read-modify-write by port 1 while port 0 requests continuously
        set_in(0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h05, 8'h00);
        @(negedge clk); chk("lock s0 owner", 32'(owner), 32'd0);
        next_cycle();
        set_in(1, 0, 0, 8'h10, 8'h00, 1, 0, 1, 8'h05, 8'h00);
        @(negedge clk); chk("lock s1 owner", 32'(owner), 32'd2);
        chk("lock s1 ReadEn", 32'(ReadEn), 32'd1);
        next_cycle();
        @(negedge clk); chk("lock s2 p1_ack", 32'(p1_ack), 32'd1);
        chk("lock s2 p1_rdat", 32'(p1_rdat), 32'h07);
        chk("lock s2 p0_ack", 32'(p0_ack), 32'd0);
        next_cycle();
        set_in(1, 0, 0, 8'h10, 8'h00, 1, 1, 1, 8'h05, 8'h08);
        @(negedge clk); chk("lock s3 owner", 32'(owner), 32'd2);
        chk("lock s3 WriteEn", 32'(WriteEn), 32'd0);
        next_cycle();
        @(negedge clk); chk("lock s4 WriteEn", 32'(WriteEn), 32'd1);
        chk("lock s4 DatIn", 32'(DatIn), 32'h08);
        chk("lock s4 MemAdr", 32'(MemAdr), 32'h05);
        next_cycle();
        @(negedge clk); chk("lock s5 p1_ack", 32'(p1_ack), 32'd1);
        chk("lock s5 p1_rdat", 32'(p1_rdat), 32'h07);
        next_cycle();
        set_in(1, 0, 0, 8'h10, 8'h00, 0, 0, 1, 8'h00, 8'h00);
        @(negedge clk); chk("lock s6 owner", 32'(owner), 32'd2);
        chk("lock s6 p0_ack", 32'(p0_ack), 32'd0);
        next_cycle();
        set_in(1, 0, 0, 8'h10, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        @(negedge clk); chk("lock s7 owner", 32'(owner), 32'd2);
        chk("lock s7 p0_ack", 32'(p0_ack), 32'd0);
        next_cycle();
        @(negedge clk); chk("lock s8 owner", 32'(owner), 32'd0);
        next_cycle();
        @(negedge clk); chk("lock s9 owner", 32'(owner), 32'd1);
        chk("lock s9 MemAdr", 32'(MemAdr), 32'h10);
        next_cycle();
        @(negedge clk); chk("lock s10 p0_ack", 32'(p0_ack), 32'd1);
        chk("lock s10 p0_rdat", 32'(p0_rdat), 32'hA5);
        chk("mem05 after rmw", 32'(mem[8'h05]), 32'h08);
        next_cycle();
        set_in(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        @(negedge clk); chk("lock s11 owner", 32'(owner), 32'd0);
        chk("lock s11 p0_ack", 32'(p0_ack), 32'd0);
        next_cycle();

        // Port 0 withdraws its write request while in ACC0
        set_in(1, 1, 0, 8'h40, 8'h55, 0, 0, 0, 8'h00, 8'h00);
        @(negedge clk); chk("viol v0 owner", 32'(owner), 32'd0);
        next_cycle();
        set_in(0, 1, 0, 8'h40, 8'h55, 0, 0, 0, 8'h00, 8'h00);
        @(negedge clk); chk("viol v1 owner", 32'(owner), 32'd1);
        chk("viol v1 WriteEn", 32'(WriteEn), 32'd0);
        next_cycle();
        @(negedge clk); chk("viol v2 owner", 32'(owner), 32'd0);
        chk("viol v2 p0_ack", 32'(p0_ack), 32'd0);
        chk("viol mem40", 32'(mem[8'h40]), 32'h00);
        next_cycle();

        // Reset lands while port 1 is in ACC1 with a write
        set_in(0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 8'h30, 8'hFF);
        @(negedge clk); chk("rst r0 owner", 32'(owner), 32'd0);
        next_cycle();
        reset = 1'b1;
        @(negedge clk); chk("rst r1 owner", 32'(owner), 32'd2);
        chk("rst r1 MemAdr", 32'(MemAdr), 32'h30);
        chk("rst r1 WriteEn", 32'(WriteEn), 32'd0);
        next_cycle();
        reset = 1'b0;
        set_in(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00);
        @(negedge clk); chk("rst r2 owner", 32'(owner), 32'd0);
        chk("rst r2 p1_ack", 32'(p1_ack), 32'd0);
        chk("rst r2 p1_rdat", 32'(p1_rdat), 32'd0);
        chk("rst r2 p0_rdat", 32'(p0_rdat), 32'd0);
        chk("rst mem30", 32'(mem[8'h30]), 32'h11);
        next_cycle();
        @(negedge clk); chk("rst r3 p1_ack", 32'(p1_ack), 32'd0);
        chk("rst r3 owner", 32'(owner), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
